// File: rtl/ads131_cmd_sequencer_if.sv
// Command-frame handshake between the ADS131 sequencer (master) and the SPI frame engine (slave).
interface ads131_cmd_sequencer_if;
   logic        frame_start;
   logic [31:0] frame_tx_word;
   logic        frame_done;
   logic [31:0] frame_rx_word;

   modport master (output frame_start, output frame_tx_word, input frame_done, input frame_rx_word);
   modport slave  (input frame_start, input frame_tx_word, output frame_done, output frame_rx_word);
endinterface

// File: rtl/ads131_cmd_sequencer.sv
// ADS131A0x link controller: hardware reset, checked power-up command sequence, then DRDY-driven data reads.
module ads131_cmd_sequencer #(
   parameter int unsigned RESET_LOW_CYCLES  = 250000,
   parameter int unsigned RESET_WAIT_CYCLES = 1000000,
   parameter logic [31:0] ENABLE_WORD       = 32'h4F0F_0000,
   parameter int unsigned MAX_RETRIES       = 15,
   parameter int unsigned FRAME_TIMEOUT     = 4096
) (
   input  logic                          system_clock,
   input  logic                          reset_n,
   input  logic                          start,
   output logic                          adc_reset_n,
   input  logic                          adc_drdy_n,
   ads131_cmd_sequencer_if.master        frame,
   output logic                          init_done,
   output logic                          init_error,
   output logic                          sample_valid,
   output logic [31:0]                   sample_word,
   output logic                          overrun,
   output logic [3:0]                    retry_count,
   output logic [3:0]                    state_dbg
);

   localparam logic [19:0] LOW_LAST  = 20'(RESET_LOW_CYCLES - 1);
   localparam logic [19:0] WAIT_LAST = 20'(RESET_WAIT_CYCLES - 1);
   localparam logic [11:0] TMO_LAST  = 12'(FRAME_TIMEOUT - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      RST_LOW  = 4'd1,
      RST_WAIT = 4'd2,
      CMD      = 4'd3,
      CMD_WAIT = 4'd4,
      CHK      = 4'd5,
      CHK_WAIT = 4'd6,
      EVAL     = 4'd7,
      RUN_IDLE = 4'd8,
      RUN_WAIT = 4'd9,
      ERROR    = 4'd10
   } state_t;

   state_t      state;
   logic [2:0]  step;
   logic [19:0] dly_cnt;
   logic [11:0] tmo_cnt;
   logic [15:0] resp;
   logic        resp_ok;
   logic        drdy_meta, drdy_sync, drdy_prev;
   logic        drdy_fall;
   logic        tmo_hit;
   logic [31:0] step_cmd;
   logic [15:0] step_exp;

   assign state_dbg = state;
   assign drdy_fall = drdy_prev & ~drdy_sync;
   assign tmo_hit   = (tmo_cnt == TMO_LAST);

   // DRDY idles high, so the synchroniser resets high to avoid a false edge out of reset.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         drdy_meta <= 1'b1;
         drdy_sync <= 1'b1;
         drdy_prev <= 1'b1;
      end else begin
         drdy_meta <= adc_drdy_n;
         drdy_sync <= drdy_meta;
         drdy_prev <= drdy_sync;
      end
   end

   always_comb begin
      step_cmd = 32'h0000_0000;
      step_exp = 16'hFF04;
      case (step)
         3'd1:    begin step_cmd = 32'h0655_0000; step_exp = 16'h0655; end
         3'd2:    begin step_cmd = ENABLE_WORD;   step_exp = 16'h2F0F; end
         3'd3:    begin step_cmd = 32'h0033_0000; step_exp = 16'h0033; end
         3'd4:    begin step_cmd = 32'h0555_0000; step_exp = 16'h0555; end
         default: begin step_cmd = 32'h0000_0000; step_exp = 16'hFF04; end
      endcase
   end

   // Counters default to zero each cycle and only advance while a state is held,
   // so every state entry starts them from zero.
   always_ff @(posedge system_clock or negedge reset_n) begin
      if (!reset_n) begin
         state               <= IDLE;
         step                <= 3'd0;
         dly_cnt             <= '0;
         tmo_cnt             <= '0;
         resp                <= '0;
         resp_ok             <= 1'b0;
         adc_reset_n         <= 1'b1;
         frame.frame_start   <= 1'b0;
         frame.frame_tx_word <= '0;
         init_done           <= 1'b0;
         init_error          <= 1'b0;
         sample_valid        <= 1'b0;
         sample_word         <= '0;
         overrun             <= 1'b0;
         retry_count         <= '0;
      end else begin
         frame.frame_start <= 1'b0;
         sample_valid      <= 1'b0;
         overrun           <= 1'b0;
         dly_cnt           <= '0;
         tmo_cnt           <= '0;
         case (state)
            IDLE, ERROR: begin
               if (start) begin
                  init_done   <= 1'b0;
                  init_error  <= 1'b0;
                  step        <= 3'd0;
                  retry_count <= '0;
                  adc_reset_n <= 1'b0;
                  state       <= RST_LOW;
               end
            end
            RST_LOW: begin
               if (dly_cnt == LOW_LAST) begin
                  adc_reset_n <= 1'b1;
                  state       <= RST_WAIT;
               end else begin
                  dly_cnt <= dly_cnt + 20'd1;
               end
            end
            RST_WAIT: begin
               if (dly_cnt == WAIT_LAST) state <= CMD;
               else dly_cnt <= dly_cnt + 20'd1;
            end
            CMD: begin
               frame.frame_start   <= 1'b1;
               frame.frame_tx_word <= step_cmd;
               state               <= CMD_WAIT;
            end
            CMD_WAIT: begin
               if (frame.frame_done) begin
                  state <= CHK;
               end else if (tmo_hit) begin
                  resp_ok <= 1'b0;
                  state   <= EVAL;
               end else begin
                  tmo_cnt <= tmo_cnt + 12'd1;
               end
            end
            // The ADC answers a command one frame late, so a null frame fetches the response.
            CHK: begin
               frame.frame_start   <= 1'b1;
               frame.frame_tx_word <= 32'h0000_0000;
               state               <= CHK_WAIT;
            end
            CHK_WAIT: begin
               if (frame.frame_done) begin
                  resp    <= frame.frame_rx_word[31:16];
                  resp_ok <= 1'b1;
                  state   <= EVAL;
               end else if (tmo_hit) begin
                  resp_ok <= 1'b0;
                  state   <= EVAL;
               end else begin
                  tmo_cnt <= tmo_cnt + 12'd1;
               end
            end
            EVAL: begin
               if (resp_ok && (resp == step_exp)) begin
                  retry_count <= '0;
                  if (step == 3'd4) begin
                     init_done <= 1'b1;
                     state     <= RUN_IDLE;
                  end else begin
                     step  <= step + 3'd1;
                     state <= CMD;
                  end
               end else if (retry_count < RETRY_MAX) begin
                  retry_count <= retry_count + 4'd1;
                  state       <= CMD;
               end else begin
                  init_error <= 1'b1;
                  state      <= ERROR;
               end
            end
            RUN_IDLE: begin
               if (drdy_fall) begin
                  frame.frame_start   <= 1'b1;
                  frame.frame_tx_word <= 32'h0000_0000;
                  state               <= RUN_WAIT;
               end
            end
            RUN_WAIT: begin
               if (drdy_fall) overrun <= 1'b1;
               if (frame.frame_done) begin
                  sample_word  <= frame.frame_rx_word;
                  sample_valid <= 1'b1;
                  state        <= RUN_IDLE;
               end else if (tmo_hit) begin
                  state <= RUN_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 12'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ads131_cmd_sequencer.md
Name: ads131_cmd_sequencer

Overview:
- Sequencing controller for the ADS131A0x SPI link.
- Owns the ADC hardware-reset pin and issues 32-bit command frames to an SPI frame engine through a start/done handshake.
- Runs the power-up sequence READY -> UNLOCK -> WREG ADC_ENA -> WAKEUP -> LOCK, checking each response with bounded retries and a per-frame timeout.
- After a successful init it converts DRDY falling edges into data-read frames and presents the captured words downstream.

Parameters:
- RESET_LOW_CYCLES, 250000: cycles adc_reset_n is held low (5 ms at 50 MHz).
- RESET_WAIT_CYCLES, 1000000: cycles waited after adc_reset_n rises, before the first frame (20 ms).
- ENABLE_WORD, 32'h4F0F_0000: WREG ADC_ENA frame. Its expected response is 16'h2F0F.
- MAX_RETRIES, 15: maximum repeats of one init step before error (4-bit).
- FRAME_TIMEOUT, 4096: cycles allowed from frame_start to frame_done.

Ports:
- system_clock  in  1  block clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins init from IDLE or ERROR
- adc_reset_n  out  1  ADC RESET pin, active low
- adc_drdy_n  in  1  ADC DRDY, active low, asynchronous
- frame_start  out  1  one-cycle pulse requesting a 32-bit SPI frame
- frame_tx_word  out  32  MOSI word for the frame
- frame_done  in  1  one-cycle pulse: frame finished
- frame_rx_word  in  32  MISO word; valid while frame_done=1
- init_done  out  1  level; init sequence passed
- init_error  out  1  level; retries exhausted
- sample_valid  out  1  one-cycle pulse
- sample_word  out  32  last captured data frame
- overrun  out  1  one-cycle pulse: DRDY edge lost
- retry_count  out  4  retries used in current step
- state_dbg  out  4  present state encoding

Behaviour:
- Clock and reset
  - Single clock domain.
  - adc_drdy_n passes through a 2-FF synchroniser plus an edge register. A falling edge is the synchronised value going 1 -> 0 (3 cycles of latency).
- Reset values
  - adc_reset_n=1, frame_start=0, frame_tx_word=0, init_done=0, init_error=0, sample_valid=0, sample_word=0, overrun=0, retry_count=0.
  - State is IDLE; step index is 0; all counters are 0.
- States (state_dbg encoding)
  - IDLE(0), RST_LOW(1), RST_WAIT(2), CMD(3), CMD_WAIT(4), CHK(5), CHK_WAIT(6), EVAL(7), RUN_IDLE(8), RUN_WAIT(9), ERROR(10).
- Reset phase
  - IDLE: on start, clear init_done, init_error, step and retry_count, then go to RST_LOW.
  - RST_LOW: drive adc_reset_n=0 for exactly RESET_LOW_CYCLES cycles, then go to RST_WAIT.
  - RST_WAIT: drive adc_reset_n=1 for RESET_WAIT_CYCLES cycles, then go to CMD.
- Init steps (command word / expected rx[31:16])
  - Step 0: 32'h0000_0000 / 16'hFF04
  - Step 1: 32'h0655_0000 / 16'h0655
  - Step 2: ENABLE_WORD / 16'h2F0F
  - Step 3: 32'h0033_0000 / 16'h0033
  - Step 4: 32'h0555_0000 / 16'h0555
- Frame handshake
  - CMD: pulse frame_start for one cycle with frame_tx_word set to the step's command word, then go to CMD_WAIT.
  - frame_tx_word holds until the matching frame_done.
  - frame_done is only honoured in the *_WAIT states.
- Response check
  - CHK issues a null frame (32'h0000_0000). Its rx word carries the response to the preceding command.
  - CHK_WAIT latches frame_rx_word[31:16] on frame_done. EVAL compares it with the step's expected value.
  - A timeout in CMD_WAIT or CHK_WAIT (FRAME_TIMEOUT cycles without frame_done) goes straight to EVAL as a mismatch.
  - Match: step+1, retry_count=0, back to CMD. After step 4, set init_done=1 and go to RUN_IDLE.
  - Mismatch with retry_count<MAX_RETRIES: retry_count+1, repeat the same step from CMD.
  - Mismatch with retry_count==MAX_RETRIES: set init_error=1 and go to ERROR. adc_reset_n stays 1.
- Run phase
  - RUN_IDLE: on a DRDY falling edge, issue a null frame and go to RUN_WAIT.
  - RUN_WAIT: on frame_done, sample_word<=frame_rx_word and sample_valid=1 for one cycle, then go to RUN_IDLE.
  - RUN_WAIT timeout: return to RUN_IDLE; no sample_valid.
- Boundary conditions
  - DRDY falling edge during RUN_WAIT: overrun pulses for 1 cycle. The edge is dropped, not queued.
  - start while busy (any state except IDLE/ERROR) is ignored.
  - start in ERROR clears init_error and restarts from RST_LOW.
  - reset_n low at any time, mid-frame included, returns all registers immediately to reset values. A late frame_done after reset is ignored because the block is in IDLE.
  - A DRDY edge in the same cycle as the last step's success is ignored. Run mode arms on the next cycle.
- Counters
  - The delay counter is 20 bits; the timeout counter is 12 bits. Both clear on every state entry.
  - retry_count saturates at MAX_RETRIES; it never wraps.

Test Plan:
- All five expected responses returned first try (RESET_LOW_CYCLES=10, RESET_WAIT_CYCLES=20) -> adc_reset_n low exactly 10 cycles; 10 frames in order 0000,0000,0655,0000,4F0F,0000,0033,0000,0555,0000; init_done=1.
- Step 0 returns 16'h0000 twice, then 16'hFF04 -> retry_count reaches 2, clears to 0; sequence completes.
- Step 1 always returns 16'h0000, MAX_RETRIES=3 -> 4 attempts, init_error=1, state_dbg=10; start -> init_error=0, adc_reset_n low again.
- Frame engine withholds frame_done, FRAME_TIMEOUT=16 -> EVAL reached 16 cycles after frame_start; counted as a retry.
- Run mode, DRDY toggled, rx=32'h1234_5678 -> one frame per falling edge; sample_word=32'h1234_5678 with a single sample_valid pulse.
- Second DRDY falling edge while RUN_WAIT active; reset_n pulsed mid-CMD_WAIT -> overrun pulses once; after reset, all outputs at reset values and state_dbg=0.
